// File: rtl/fade_pkg.sv
// Shared types and constants for the background palette fade controller.
//   fade_state_t : brightness FSM states
//   LEVEL_MAX    : full-brightness level (identity scaling)
//   LEVEL_W      : width of the brightness level (0..LEVEL_MAX)
package fade_pkg;

  typedef enum logic [1:0] {
    BRIGHT,
    FADING_OUT,
    DARK,
    FADING_IN
  } fade_state_t;

  localparam int LEVEL_MAX = 16;
  localparam int LEVEL_W   = 5;

endpackage

// File: rtl/rgb_scaler.sv
// Purely combinational per-channel brightness scaler.
//   rgb_i   in  12  {red, green, blue}, 4 bits each
//   level_i in   5  brightness 0..16
//   rgb_o   out 12  each channel = (c * level) >> 4
// With level 16 the product is c << 4, so the output equals the input exactly.
module rgb_scaler
  import fade_pkg::*;
(
  input  logic [11:0]        rgb_i,
  input  logic [LEVEL_W-1:0] level_i,
  output logic [11:0]        rgb_o
);

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    logic [8:0] prod;
    assign prod = {5'b0, rgb_i[gi*4 +: 4]} * {4'b0, level_i};
    // Product never exceeds 15*16 = 240, so bits [7:4] hold the whole result.
    assign rgb_o[gi*4 +: 4] = 4'(prod >> 4);
  end

endmodule

// File: rtl/bg_palette_fade_ctrl.sv
// Frame-synchronous brightness controller between pixel fetch and the
// 16-entry background palette. Forwards the palette index, scales the
// returned RGB by a global level (0..16) that steps once every
// FRAMES_PER_STEP vsync pulses while fading.
//   clk, reset_n                 clock, synchronous active-low reset
//   vsync_pulse                  start-of-vblank strobe (steps happen here only)
//   fade_out_req / fade_in_req   level-sensitive fade requests (out wins)
//   pix_valid, pix_index         incoming pixel
//   pal_index                    combinational copy of pix_index
//   pal_red/green/blue           palette RGB for pal_index, same cycle
//   rgb_out, rgb_valid           scaled pixel, 2-cycle latency
//   level, busy, done            brightness, fading flag, terminal pulse
module bg_palette_fade_ctrl
  import fade_pkg::*;
#(
  parameter int unsigned FRAMES_PER_STEP = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               vsync_pulse,
  input  logic               fade_out_req,
  input  logic               fade_in_req,
  input  logic               pix_valid,
  input  logic [3:0]         pix_index,
  output logic [3:0]         pal_index,
  input  logic [3:0]         pal_red,
  input  logic [3:0]         pal_green,
  input  logic [3:0]         pal_blue,
  output logic [11:0]        rgb_out,
  output logic               rgb_valid,
  output logic [LEVEL_W-1:0] level,
  output logic               busy,
  output logic               done
);

  localparam logic [7:0]         CNT_LAST = 8'(FRAMES_PER_STEP - 1);
  localparam logic [LEVEL_W-1:0] LVL_FULL = LEVEL_W'(LEVEL_MAX);

  fade_state_t        state_q;
  logic [LEVEL_W-1:0] level_q;
  logic [7:0]         cnt_q;
  logic               done_q;
  logic               busy_q;

  logic [LEVEL_W-1:0] level_dn;
  logic [LEVEL_W-1:0] level_up;

  // Saturating neighbours: a reversal taken right at a terminal level must
  // not wrap past 0 or LEVEL_MAX.
  assign level_dn = (level_q == '0) ? '0 : level_q - 1'b1;
  assign level_up = (level_q >= LVL_FULL) ? LVL_FULL : level_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= BRIGHT;
      level_q <= LVL_FULL;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (fade_out_req && (state_q == BRIGHT || state_q == FADING_IN)) begin
        state_q <= FADING_OUT;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
      end else if (fade_in_req && !fade_out_req &&
                   (state_q == DARK || state_q == FADING_OUT)) begin
        state_q <= FADING_IN;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
      end else if (vsync_pulse && (state_q == FADING_OUT || state_q == FADING_IN)) begin
        // A vsync on a state-change cycle falls into the branches above and
        // is therefore not counted toward the new state.
        if (cnt_q == CNT_LAST) begin
          cnt_q <= '0;
          if (state_q == FADING_OUT) begin
            level_q <= level_dn;
            if (level_dn == '0) begin
              state_q <= DARK;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            level_q <= level_up;
            if (level_up == LVL_FULL) begin
              state_q <= BRIGHT;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
    end
  end

  // Pixel pipeline: stage 1 captures raw RGB, valid and the level in force
  // during the fetch cycle; stage 2 registers the scaled result.
  logic [11:0]        s1_rgb_q;
  logic               s1_valid_q;
  logic [LEVEL_W-1:0] s1_level_q;
  logic [11:0]        scaled;
  logic [11:0]        rgb_out_d;
  logic [11:0]        rgb_out_q;
  logic               rgb_valid_q;

  rgb_scaler u_scaler (
    .rgb_i   (s1_rgb_q),
    .level_i (s1_level_q),
    .rgb_o   (scaled)
  );

  assign rgb_out_d = s1_valid_q ? scaled : 12'h000;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_rgb_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_level_q  <= LVL_FULL;
      rgb_out_q   <= '0;
      rgb_valid_q <= 1'b0;
    end else begin
      s1_rgb_q    <= {pal_red, pal_green, pal_blue};
      s1_valid_q  <= pix_valid;
      s1_level_q  <= level_q;
      rgb_out_q   <= rgb_out_d;
      rgb_valid_q <= s1_valid_q;
    end
  end

  assign pal_index = pix_index;
  assign rgb_out   = rgb_out_q;
  assign rgb_valid = rgb_valid_q;
  assign level     = level_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_bg_palette_fade_ctrl.sv
// Self-checking bench for bg_palette_fade_ctrl (FRAMES_PER_STEP = 2).
// Pixel expectations go into a scoreboard queue tagged with the cycle they
// must appear on; a negedge monitor pops and compares them.
module tb_bg_palette_fade_ctrl;

  localparam int FPS = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vsync_pulse;
  logic        fade_out_req;
  logic        fade_in_req;
  logic        pix_valid;
  logic [3:0]  pix_index;
  logic [3:0]  pal_index;
  logic [3:0]  pal_red, pal_green, pal_blue;
  logic [11:0] rgb_out;
  logic        rgb_valid;
  logic [4:0]  level;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  bg_palette_fade_ctrl #(.FRAMES_PER_STEP(FPS)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .vsync_pulse  (vsync_pulse),
    .fade_out_req (fade_out_req),
    .fade_in_req  (fade_in_req),
    .pix_valid    (pix_valid),
    .pix_index    (pix_index),
    .pal_index    (pal_index),
    .pal_red      (pal_red),
    .pal_green    (pal_green),
    .pal_blue     (pal_blue),
    .rgb_out      (rgb_out),
    .rgb_valid    (rgb_valid),
    .level        (level),
    .busy         (busy),
    .done         (done)
  );

  // Palette model: combinational lookup on the DUT's index output.
  logic [11:0] pal_mem [16];
  assign {pal_red, pal_green, pal_blue} = pal_mem[pal_index];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;

  typedef struct {
    int          at_cyc;
    logic        valid;
    logic [11:0] rgb;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [11:0] scale(input logic [11:0] rgb, input int lvl);
    int r, g, b;
    r = int'(rgb[11:8]) * lvl / 16;
    g = int'(rgb[7:4])  * lvl / 16;
    b = int'(rgb[3:0])  * lvl / 16;
    return {r[3:0], g[3:0], b[3:0]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  // Scoreboard monitor: one line per pixel transaction.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].at_cyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      $display("pix cyc=%0d valid=%0b rgb=%03h exp_valid=%0b exp_rgb=%03h",
               cyc, rgb_valid, rgb_out, e.valid, e.rgb);
      check("rgb_valid", 32'(rgb_valid), 32'(e.valid));
      check("rgb_out", 32'(rgb_out), 32'(e.rgb));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one pixel slot for the current cycle; it must emerge 2 cycles later.
  task automatic drive_pix(input logic v, input logic [3:0] idx, input int lvl);
    exp_t e;
    pix_valid = v;
    pix_index = idx;
    e.at_cyc  = cyc + 2;
    e.valid   = v;
    e.rgb     = v ? scale(pal_mem[idx], lvl) : 12'h000;
    sb.push_back(e);
  endtask

  task automatic vsync_once();
    vsync_pulse = 1'b1;
    tick();
    vsync_pulse = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) pal_mem[i] = 12'((i * 273) ^ 'h5A3);
    pal_mem[3] = 12'h563;
    pal_mem[5] = 12'hA97;

    reset_n      = 1'b0;
    vsync_pulse  = 1'b0;
    fade_out_req = 1'b0;
    fade_in_req  = 1'b0;
    pix_valid    = 1'b0;
    pix_index    = 4'h0;
    repeat (3) tick();
    reset_n = 1'b1;

    // Reset state
    check("rst_level", 32'(level), 32'd16);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rgb_valid", 32'(rgb_valid), 32'd0);
    check("rst_rgb_out", 32'(rgb_out), 32'd0);

    // Identity scaling at full brightness
    drive_pix(1'b1, 4'd3, 16);
    tick();
    repeat (3) begin drive_pix(1'b0, 4'd3, 16); tick(); end
    pix_valid = 1'b0;
    tick();

    // Fade out to black: one step per 2 vsyncs
    fade_out_req = 1'b1;
    tick();
    fade_out_req = 1'b0;
    check("fo_busy", 32'(busy), 32'd1);
    check("fo_level0", 32'(level), 32'd16);
    for (int k = 1; k <= 32; k++) begin
      vsync_once();
      check("fade_out_level", 32'(level), 32'(16 - k / 2));
      if (k == 16) begin
        drive_pix(1'b1, 4'd5, 8);
        tick();
        drive_pix(1'b0, 4'd5, 8);
        tick();
        pix_valid = 1'b0;
        repeat (2) tick();
      end else begin
        repeat (3) tick();
      end
    end
    check("dark_busy", 32'(busy), 32'd0);
    check("dark_done_cnt", 32'(done_cnt), 32'd1);

    // Fade in from DARK up to level 5, then reset mid-fade
    fade_in_req = 1'b1;
    tick();
    fade_in_req = 1'b0;
    check("fi_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      vsync_once();
      check("fade_in_level", 32'(level), 32'(k / 2));
      repeat (3) tick();
    end
    pix_valid = 1'b1;
    pix_index = 4'd3;
    repeat (2) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mrst_level", 32'(level), 32'd16);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_valid0", 32'(rgb_valid), 32'd0);
    check("mrst_rgb0", 32'(rgb_out), 32'd0);
    tick();
    check("mrst_valid1", 32'(rgb_valid), 32'd0);
    tick();
    check("mrst_valid2", 32'(rgb_valid), 32'd1);
    check("mrst_rgb2", 32'(rgb_out), 32'h563);
    pix_valid = 1'b0;
    repeat (3) tick();

    // fade_in_req alone in BRIGHT is ignored
    fade_in_req = 1'b1;
    repeat (3) tick();
    check("fi_bright_busy", 32'(busy), 32'd0);
    vsync_once();
    vsync_once();
    check("fi_bright_level", 32'(level), 32'd16);
    fade_in_req = 1'b0;
    tick();

    // Both requests: fade out wins
    fade_out_req = 1'b1;
    fade_in_req  = 1'b1;
    tick();
    fade_out_req = 1'b0;
    fade_in_req  = 1'b0;
    check("both_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= 12; k++) begin
      vsync_once();
      check("rev_out_level", 32'(level), 32'(16 - k / 2));
      repeat (2) tick();
    end
    // Half-way through the next step, then reverse
    vsync_once();
    check("rev_half_level", 32'(level), 32'd10);
    tick();
    fade_in_req = 1'b1;
    tick();
    fade_in_req = 1'b0;
    check("rev_busy", 32'(busy), 32'd1);
    check("rev_nojump", 32'(level), 32'd10);
    vsync_once();
    check("rev_cnt_cleared", 32'(level), 32'd10);
    tick();
    vsync_once();
    check("rev_first_step", 32'(level), 32'd11);
    tick();
    for (int k = 1; k <= 10; k++) begin
      vsync_once();
      check("rev_in_level", 32'(level), 32'(11 + k / 2));
      repeat (2) tick();
    end
    check("rev_end_busy", 32'(busy), 32'd0);
    check("rev_done_cnt", 32'(done_cnt), 32'd2);

    // Alternating pix_valid on a continuous index stream
    for (int i = 0; i < 12; i++) begin
      drive_pix((i % 2) == 0, 4'(i), 16);
      tick();
    end
    repeat (2) begin drive_pix(1'b0, 4'd0, 16); tick(); end
    pix_valid = 1'b0;
    repeat (4) tick();

    check("sb_drained", 32'(sb.size()), 32'd0);
    check("final_done_cnt", 32'(done_cnt), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
